multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 37 +++
 rtl/multicycle_controller_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// Optional illegal-op trap is enabled by defining CTRL_ILLEGAL_TRAP_EN.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ,
    S_ERROR
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALUOp/funct to ALUControl decode.
// Used by multicycle_controller (see CTRL_ILLEGAL_TRAP_EN in the top).
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    unique case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3_i)
          3'b000:
            alu_ctrl_o = (op5_i & funct7b5_i)
                       ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory wait timeout.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in ERROR.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       MemTimeout,
  output logic       Illegal
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d, st;
  logic [7:0] cnt_q, cnt_d;
  logic       waiting, timeout;
  logic       ir_write, mem_write, reg_write;
  logic       branch, pc_update;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign waiting = (state_q == S_FETCH)
                 | (state_q == S_MEMREAD)
                 | (state_q == S_MEMWRITE);
  assign timeout = waiting & ~MemReady
                 & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECUTER;
          OP_ITYPE: state_d = S_EXECUTEI;
          OP_JAL:   state_d = S_JAL;
          OP_BEQ:   state_d = S_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:  state_d = S_ERROR;
`else
          default:  state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE:
        if (MemReady) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = state_q;
    endcase
    // A timed-out wait abandons the access and refetches
    if (timeout) state_d = S_FETCH;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (timeout || (state_d != state_q))
      cnt_d = '0;
    else if (waiting && !MemReady)
      cnt_d = cnt_q + 8'd1;
  end

  // Outputs in reset mirror FETCH with enables masked below
  assign st = reset ? S_FETCH : state_q;

  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    branch    = 1'b0;
    pc_update = 1'b0;
    unique case (st)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite    = ~reset
                    & ((branch & Zero) | pc_update);
  assign IRWrite    = ~reset & ir_write;
  assign MemWrite   = ~reset & mem_write & ~timeout;
  assign RegWrite   = ~reset & reg_write;
  assign MemTimeout = ~reset & timeout;

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      (op == OP_STORE): ImmSrc = 2'b01;
      (op == OP_BEQ):   ImmSrc = 2'b10;
      (op == OP_JAL):   ImmSrc = 2'b11;
      default:          ImmSrc = 2'b00;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Illegal = (state_q == S_ERROR);
`else
  assign Illegal = 1'b0;
`endif

  alu_decoder u_alu_dec (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .op5_i      (op[5]),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, corner sequences
// and random stimulus against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int MT = 16;

  localparam int M_FETCH = 0, M_DECODE = 1, M_MEMADR = 2;
  localparam int M_MEMREAD = 3, M_MEMWB = 4, M_MEMWRITE = 5;
  localparam int M_EXECR = 6, M_EXECI = 7, M_ALUWB = 8;
  localparam int M_JAL = 9, M_BEQ = 10, M_ERROR = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       MemTimeout, Illegal;

  multicycle_controller #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MemTimeout(MemTimeout), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       MemTimeout, Illegal;
  } out_t;

  typedef struct {
    bit adr, mw, rw, br, pcu, rdy;
    bit [1:0] rs, sa, sb, aop;
  } row_t;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    int         cyc;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       pcw;
  } vec_t;

  row_t rows[12];
  vec_t tab[16];
  int   ntab;
  int   ms, mcnt;
  out_t obs;
  int   total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic void set_row(int i, bit adr, bit mw, bit rw,
      bit br, bit pcu, bit rdy, bit [1:0] rs, bit [1:0] sa,
      bit [1:0] sb, bit [1:0] aop);
    rows[i] = '{adr, mw, rw, br, pcu, rdy, rs, sa, sb, aop};
  endfunction

  function automatic bit is_wait(int s);
    return s == M_FETCH || s == M_MEMREAD || s == M_MEMWRITE;
  endfunction

  function automatic bit m_timeout();
    return !reset && is_wait(ms) && !MemReady && mcnt == MT - 1;
  endfunction

  function automatic logic [2:0] m_alu(bit [1:0] aop);
    if (aop == 2'd0) return 3'd0;
    if (aop == 2'd1) return 3'd1;
    case (funct3)
      3'd0: return (op[5] && funct7b5) ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] m_imm();
    if (op == 7'b0100011) return 2'd1;
    if (op == 7'b1100011) return 2'd2;
    if (op == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  function automatic out_t model_out();
    out_t e;
    row_t r;
    bit   to, pcu;
    r  = rows[reset ? M_FETCH : ms];
    to = m_timeout();
    e  = '0;
    e.AdrSrc     = r.adr;
    e.ResultSrc  = r.rs;
    e.ALUSrcA    = r.sa;
    e.ALUSrcB    = r.sb;
    e.IRWrite    = r.rdy & MemReady;
    pcu          = r.pcu | (r.rdy & MemReady);
    e.PCWrite    = (r.br & Zero) | pcu;
    e.MemWrite   = r.mw & !to;
    e.RegWrite   = r.rw;
    e.MemTimeout = to;
    if (reset) begin
      e.PCWrite  = 0;
      e.IRWrite  = 0;
      e.MemWrite = 0;
      e.RegWrite = 0;
    end
    e.ImmSrc     = m_imm();
    e.ALUControl = m_alu(r.aop);
    e.Illegal    = (ms == M_ERROR);
    return e;
  endfunction

  function automatic int m_decode();
    if (op == 7'b0000011 || op == 7'b0100011) return M_MEMADR;
    if (op == 7'b0110011) return M_EXECR;
    if (op == 7'b0010011) return M_EXECI;
    if (op == 7'b1101111) return M_JAL;
    if (op == 7'b1100011) return M_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
    return M_ERROR;
`else
    return M_FETCH;
`endif
  endfunction

  function automatic int m_next();
    case (ms)
      M_FETCH:    return MemReady ? M_DECODE : M_FETCH;
      M_DECODE:   return m_decode();
      M_MEMADR:   return op[5] ? M_MEMWRITE : M_MEMREAD;
      M_MEMREAD:  return MemReady ? M_MEMWB : M_MEMREAD;
      M_MEMWRITE: return MemReady ? M_FETCH : M_MEMWRITE;
      M_EXECR, M_EXECI, M_JAL: return M_ALUWB;
      M_ERROR:    return M_ERROR;
      default:    return M_FETCH;
    endcase
  endfunction

  function automatic void model_advance();
    int ns;
    if (reset || m_timeout()) begin
      ms = M_FETCH;
      mcnt = 0;
    end else begin
      ns = m_next();
      if (ns != ms) mcnt = 0;
      else if (is_wait(ms) && !MemReady) mcnt++;
      ms = ns;
    end
  endfunction

  task automatic step(input string nm);
    @(negedge clk);
    obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
           MemTimeout, Illegal};
    chk(nm, 32'(obs), 32'(model_out()));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("reset");
    reset = 1'b0;
  endtask

  task automatic set_ins(logic [6:0] o, logic [2:0] f3,
                         logic f7, logic z);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    Zero = z;
  endtask

  // Counts cycles until MemTimeout pulses with MemReady held low
  task automatic run_to_timeout(input string nm, output int n,
                                output bit irw);
    n = 0;
    irw = 0;
    MemReady = 1'b0;
    do begin
      step(nm);
      n++;
      if (obs.IRWrite) irw = 1;
    end while (!obs.MemTimeout && n < 3 * MT);
  endtask

  initial begin
    int   k, n;
    bit   irw;
    out_t o1, o2;

    set_row(M_FETCH,    0,0,0,0,0,1, 2'b10,2'b00,2'b10,2'b00);
    set_row(M_DECODE,   0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00);
    set_row(M_MEMADR,   0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00);
    set_row(M_MEMREAD,  1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00);
    set_row(M_MEMWB,    0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00);
    set_row(M_MEMWRITE, 1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00);
    set_row(M_EXECR,    0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10);
    set_row(M_EXECI,    0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10);
    set_row(M_ALUWB,    0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00);
    set_row(M_JAL,      0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00);
    set_row(M_BEQ,      0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b01);
    set_row(M_ERROR,    0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00);

    tab[0]  = '{"add",  7'b0110011, 3'b000, 0, 0, 4, 2'd0, 3'b000, 0};
    tab[1]  = '{"sub",  7'b0110011, 3'b000, 1, 0, 4, 2'd0, 3'b001, 0};
    tab[2]  = '{"addi", 7'b0010011, 3'b000, 1, 0, 4, 2'd0, 3'b000, 0};
    tab[3]  = '{"slt",  7'b0110011, 3'b010, 0, 0, 4, 2'd0, 3'b101, 0};
    tab[4]  = '{"ori",  7'b0010011, 3'b110, 0, 0, 4, 2'd0, 3'b011, 0};
    tab[5]  = '{"and",  7'b0110011, 3'b111, 0, 0, 4, 2'd0, 3'b010, 0};
    tab[6]  = '{"xor",  7'b0110011, 3'b100, 0, 0, 4, 2'd0, 3'b000, 0};
    tab[7]  = '{"lw",   7'b0000011, 3'b010, 0, 0, 5, 2'd0, 3'b000, 0};
    tab[8]  = '{"sw",   7'b0100011, 3'b010, 0, 0, 4, 2'd1, 3'b000, 0};
    tab[9]  = '{"jal",  7'b1101111, 3'b000, 0, 0, 4, 2'd3, 3'b000, 1};
    tab[10] = '{"beqT", 7'b1100011, 3'b000, 0, 1, 3, 2'd2, 3'b001, 1};
    tab[11] = '{"beqN", 7'b1100011, 3'b000, 0, 0, 3, 2'd2, 3'b001, 0};
    ntab = 12;
`ifndef CTRL_ILLEGAL_TRAP_EN
    tab[12] = '{"nop",  7'b0000000, 3'b000, 0, 0, 2, 2'd0, 3'b000, 1};
    ntab = 13;
`endif

    ms = M_FETCH;
    mcnt = 0;
    set_ins(7'b0110011, 3'b000, 0, 0);
    MemReady = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    MemReady = 1'b1;
    step("fetch0");
    for (int i = 0; i < ntab; i++) begin
      set_ins(tab[i].op, tab[i].f3, tab[i].f7, tab[i].z);
      k = 0;
      do begin
        step({tab[i].nm, "_cyc"});
        k++;
        if (k == 1) o1 = obs;
        if (k == 2) o2 = obs;
      end while (!obs.IRWrite && k < 20);
      chk({tab[i].nm, "_cycles"}, k, tab[i].cyc);
      chk({tab[i].nm, "_imm"}, o1.ImmSrc, tab[i].imm);
      chk({tab[i].nm, "_alu"}, o2.ALUControl, tab[i].alu);
      chk({tab[i].nm, "_pcw"}, o2.PCWrite, tab[i].pcw);
    end

    // lw with three wait cycles in MEMREAD
    do_reset();
    MemReady = 1'b1;
    step("lw_f");
    set_ins(7'b0000011, 3'b010, 0, 0);
    step("lw_d");
    step("lw_a");
    MemReady = 1'b0;
    n = 0;
    repeat (3) begin
      step("lw_wait");
      n += obs.AdrSrc;
    end
    MemReady = 1'b1;
    step("lw_rd");
    n += obs.AdrSrc;
    chk("lw_adrsrc_cycles", n, 4);
    step("lw_wb");
    chk("lw_wb_outs", {obs.RegWrite, obs.ResultSrc}, 3'b101);

    // Fetch timeout with MemReady never arriving
    do_reset();
    run_to_timeout("fto", n, irw);
    chk("fetch_timeout_cycle", n, MT);
    chk("fetch_timeout_irw", irw, 0);
    run_to_timeout("fto2", n, irw);
    chk("fetch_timeout_again", n, MT);

    // Reset during a stalled store
    do_reset();
    MemReady = 1'b1;
    step("sw_f");
    set_ins(7'b0100011, 3'b010, 0, 0);
    step("sw_d");
    step("sw_a");
    MemReady = 1'b0;
    step("sw_w1");
    chk("sw_memwrite", obs.MemWrite, 1);
    step("sw_w2");
    reset = 1'b1;
    step("sw_rst");
    chk("sw_rst_memwrite", obs.MemWrite, 0);
    reset = 1'b0;
    run_to_timeout("sw_post", n, irw);
    chk("sw_post_rst_count", n, MT);

    // MemReady arriving on the last allowed cycle wins
    do_reset();
    MemReady = 1'b1;
    step("race_f");
    set_ins(7'b0000011, 3'b010, 0, 0);
    step("race_d");
    step("race_a");
    MemReady = 1'b0;
    repeat (MT - 1) step("race_w");
    MemReady = 1'b1;
    step("race_last");
    chk("race_no_pulse", obs.MemTimeout, 0);
    step("race_wb");
    chk("race_wb_regwrite", obs.RegWrite, 1);

    // Store timeout suppresses MemWrite
    do_reset();
    MemReady = 1'b1;
    step("swto_f");
    set_ins(7'b0100011, 3'b010, 0, 0);
    step("swto_d");
    step("swto_a");
    MemReady = 1'b0;
    repeat (MT - 1) step("swto_w");
    step("swto_last");
    chk("swto_pulse", obs.MemTimeout, 1);
    chk("swto_memwrite", obs.MemWrite, 0);
    step("swto_fetch");
    chk("swto_fetch_rsrc", obs.ResultSrc, 2'b10);

    // Unknown opcode
    do_reset();
    MemReady = 1'b1;
    step("ill_f");
    set_ins(7'b0000000, 3'b000, 0, 0);
    step("ill_d");
`ifdef CTRL_ILLEGAL_TRAP_EN
    repeat (5) step("ill_err");
    chk("ill_held", obs.Illegal, 1);
    chk("ill_no_irw", obs.IRWrite, 0);
    reset = 1'b1;
    step("ill_rst");
    reset = 1'b0;
    step("ill_after");
    chk("ill_cleared", obs.Illegal, 0);
`else
    step("ill_next");
    chk("ill_refetch", obs.IRWrite, 1);
    chk("ill_level", obs.Illegal, 0);
`endif

    // Random traffic against the model
    do_reset();
    begin
      logic [6:0] ops[7];
      int         lowrun;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1101111, 7'b1100011, 7'b0000000};
      lowrun = 0;
      for (int c = 0; c < 3000; c++) begin
        reset = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 15) == 0)
          op = 7'($urandom);
        else
          op = ops[$urandom_range(0, 5)];
        funct3 = 3'($urandom);
        funct7b5 = 1'($urandom);
        Zero = 1'($urandom);
        if (lowrun > 0) lowrun--;
        else if ($urandom_range(0, 39) == 0)
          lowrun = $urandom_range(10, 20);
        MemReady = (lowrun == 0) && ($urandom_range(0, 3) != 0);
        step("rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
